// File: rtl/anubis_stream_ctrl_if.sv
// anubis_stream_ctrl_if: 32-bit valid/ready input and output streams of the anubis controller
interface anubis_stream_ctrl_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_new_key;
  logic        in_encrypt;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  modport master (
    output in_data, in_valid, in_new_key, in_encrypt, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_valid, in_new_key, in_encrypt, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/anubis_stream_ctrl.sv
// anubis_stream_ctrl: loads key/plaintext words, sequences the anubis core and unloads the result
module anubis_stream_ctrl #(
  parameter int CORE_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  anubis_stream_ctrl_if.slave  strm,
  output logic                 busy,
  output logic                 timeout,
  output logic                 core_reset,
  output logic                 core_encrypt,
  output logic [127:0]         core_key,
  output logic [127:0]         core_plain_text,
  input  logic [127:0]         core_cipher_text,
  input  logic                 core_end_flag
);
  localparam int RW = $clog2(CORE_RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PT, START, RUN, UNLOAD} state_t;
  state_t state, next;
  logic [1:0] cnt;
  logic [6:0] slot;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [127:0] result;
  logic end_flag_d, in_fire, out_fire, done, expired;
  assign slot = {~cnt, 5'd0};
  assign strm.in_ready = !reset && (state == IDLE || state == LOAD_KEY || state == LOAD_PT);
  assign strm.out_valid = state == UNLOAD;
  assign strm.out_data = strm.out_valid ? result[slot +: 32] : '0;
  assign busy = state != IDLE;
  assign in_fire = strm.in_valid && strm.in_ready;
  assign out_fire = strm.out_valid && strm.out_ready;
  assign done = state == RUN && core_end_flag && !end_flag_d;
  assign expired = to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (in_fire) next = strm.in_new_key ? LOAD_KEY : LOAD_PT;
      LOAD_KEY: if (in_fire && cnt == 2'd3) next = LOAD_PT;
      LOAD_PT:  if (in_fire && cnt == 2'd3) next = START;
      START:    if (rst_cnt == RW'(CORE_RST_CYCLES - 1)) next = RUN;
      RUN:      next = done ? UNLOAD : expired ? IDLE : RUN;
      UNLOAD:   if (out_fire && cnt == 2'd3) next = IDLE;
      default:  next = IDLE;
    endcase
  end
  // end_flag_d follows the core through START too, so a level already high on entry to RUN is no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rst_cnt <= '0;
      to_cnt <= '0;
      end_flag_d <= 1'b0;
      timeout <= 1'b0;
      core_reset <= 1'b1;
      core_encrypt <= 1'b1;
      core_key <= '0;
      core_plain_text <= '0;
      result <= '0;
    end else begin
      state <= next;
      core_reset <= next != RUN;
      rst_cnt <= state == START ? rst_cnt + 1'b1 : '0;
      to_cnt <= state == RUN ? to_cnt + 1'b1 : '0;
      end_flag_d <= core_end_flag;
      if (in_fire || out_fire) cnt <= cnt + 2'd1;
      if (in_fire && state == IDLE) begin
        core_encrypt <= strm.in_encrypt;
        timeout <= 1'b0;
      end
      if (in_fire && (state == LOAD_KEY || (state == IDLE && strm.in_new_key))) core_key[slot +: 32] <= strm.in_data;
      else if (in_fire) core_plain_text[slot +: 32] <= strm.in_data;
      if (done) result <= core_cipher_text;
      if (state == RUN && !done && expired) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_anubis_stream_ctrl.sv
// tb_anubis_stream_ctrl: randomized jobs through a core stub, scored against a key/xor reference model
module tb_anubis_stream_ctrl;
  localparam int CRC = 2;
  localparam int TO = 32;
  localparam int END_DELAY = 20;
  logic clk = 0, reset = 1;
  logic busy, timeout, core_reset, core_encrypt;
  logic end_flag = 0;
  logic [127:0] core_key, core_plain_text, cipher;
  int stub_mode = 0, run_cnt = 0, hold = 0, lowcnt = 0;
  int checks = 0, errors = 0;
  logic [127:0] model_key = '0;
  logic [31:0] exp_q[$];
  logic prev_stall = 0;
  logic [31:0] prev_data = 0;
  anubis_stream_ctrl_if bus();
  anubis_stream_ctrl #(.CORE_RST_CYCLES(CRC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .strm(bus), .busy(busy), .timeout(timeout),
    .core_reset(core_reset), .core_encrypt(core_encrypt), .core_key(core_key),
    .core_plain_text(core_plain_text), .core_cipher_text(cipher), .core_end_flag(end_flag)
  );
  always #5 clk = ~clk;
  assign cipher = core_encrypt ? core_plain_text ^ core_key : core_plain_text ^ ~core_key;
  // stub: mode 0 rises END_DELAY cycles after reset release, 1 never, 2 high on entry then dips
  always @(posedge clk) begin
    run_cnt <= core_reset ? 0 : run_cnt + 1;
    end_flag <= stub_mode == 1 ? 1'b0 :
                stub_mode == 2 ? (core_reset || run_cnt < 5 || run_cnt >= END_DELAY - 1) :
                (!core_reset && run_cnt >= END_DELAY - 1);
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        if (lowcnt >= hold) begin
          bus.out_ready = 1;
          lowcnt = 0;
        end else begin
          bus.out_ready = 0;
          lowcnt++;
        end
      end else begin
        bus.out_ready = hold == 0;
        lowcnt = 0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (reset) prev_stall = 0;
      else begin
        if (prev_stall && bus.out_valid) check("out_stable", bus.out_data, prev_data);
        if (bus.out_valid && bus.out_ready) begin
          check("out_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("out_word", bus.out_data, exp_q.pop_front());
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
      end
    end
  end
  task automatic do_reset();
    reset = 1;
    bus.in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_encrypt", core_encrypt, 1);
    check("rst_core_key", core_key, 0);
    check("rst_core_plain", core_plain_text, 0);
    exp_q.delete();
    model_key = '0;
    @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic push_word(input logic [31:0] d, input bit nk, input bit enc, input int gap);
    int n;
    repeat ($urandom_range(0, gap)) begin
      @(posedge clk);
      #1;
    end
    bus.in_data = d;
    bus.in_new_key = nk;
    bus.in_encrypt = enc;
    bus.in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_data = $urandom;
  endtask
  task automatic load_job(input bit nk, input bit enc, input logic [127:0] key, input logic [127:0] plain,
                          input int gap, input bit expect_out);
    logic [127:0] c, w;
    bit first;
    if (nk) model_key = key;
    c = enc ? plain ^ model_key : plain ^ ~model_key;
    if (expect_out) for (int i = 0; i < 4; i++) exp_q.push_back(c[127 - 32*i -: 32]);
    for (int i = 0; i < 8; i++) begin
      if (!nk && i < 4) continue;
      first = nk ? i == 0 : i == 4;
      w = i < 4 ? key : plain;
      push_word(w[127 - 32*(i%4) -: 32], first ? nk : 1'($urandom), first ? enc : 1'($urandom), gap);
    end
  endtask
  task automatic run_job(input bit nk, input bit enc, input logic [127:0] key, input logic [127:0] plain,
                         input int gap, input bit expect_out);
    int n;
    load_job(nk, enc, key, plain, gap, expect_out);
    n = 0;
    @(negedge clk);
    while (core_reset && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("core_reset_cycles", n, CRC);
    n = 0;
    if (expect_out) begin
      while (!bus.out_valid && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("result_latency", n, END_DELAY + 1);
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("drain_left", exp_q.size(), 0);
      check("idle_busy", busy, 0);
      check("timeout_clear", timeout, 0);
    end else begin
      while (busy && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("run_cycles", n, TO);
      check("timeout_set", timeout, 1);
      check("abort_core_reset", core_reset, 1);
      check("abort_out_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    logic [127:0] k;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.in_new_key = 0;
    bus.in_encrypt = 0;
    bus.out_ready = 1;
    do_reset();
    @(negedge clk);
    check("ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;
    run_job(1, 1, '0, '0, 0, 1);
    run_job(1, 1, 128'h000102030405060708090a0b0c0d0e0f, 128'hffffffff00000000ffffffff00000000, 0, 1);
    run_job(0, 1, '0, '0, 2, 1);
    run_job(0, 0, '0, rnd(), 2, 1);
    hold = 5;
    for (int j = 0; j < 6; j++) run_job(j == 0 ? 1'b1 : 1'($urandom), 1'($urandom), rnd(), rnd(), 3, 1);
    hold = 0;
    stub_mode = 1;
    run_job(0, 1, '0, rnd(), 1, 0);
    stub_mode = 0;
    run_job(0, 1, '0, rnd(), 1, 1);
    stub_mode = 2;
    run_job(1, 1, rnd(), rnd(), 1, 1);
    run_job(0, 0, '0, rnd(), 1, 1);
    stub_mode = 0;
    k = rnd();
    for (int i = 0; i < 4; i++) push_word(k[127 - 32*i -: 32], i == 0, 1'b1, 1);
    for (int i = 0; i < 2; i++) push_word($urandom, 1'($urandom), 1'($urandom), 1);
    do_reset();
    run_job(0, 1, '0, rnd(), 1, 1);
    hold = 5;
    load_job(1, 1, rnd(), rnd(), 1, 1);
    n = 0;
    while (exp_q.size() != 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("unload_first_word", exp_q.size(), 3);
    @(posedge clk);
    #1;
    do_reset();
    hold = 0;
    run_job(0, 1, '0, rnd(), 1, 1);
    run_job(0, 0, '0, rnd(), 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
